// File: rtl/regfile_pkg.sv
// Shared register-file constants: bus widths, reserved index/word values and
// the active levels of the reset, write and read controls.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic [REG_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG  = '0;

  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

endpackage

// File: rtl/regfile_rd_port.sv
// One source-operand read port: priority mux of reset, x0, same-cycle write
// bypass, stored word and read-disable.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] rdata_o
);

  always_comb begin
    rdata_o = '0;
    if (rst_i == RST_ENABLE) begin
      rdata_o = '0;
    end else if (raddr_i == '0) begin
      rdata_o = '0;
    end else if ((re_i == READ_ENABLE) && (we_i == WRITE_ENABLE) && (raddr_i == waddr_i)) begin
      // The write lands at this edge; forward it so id sees it this cycle.
      rdata_o = wdata_i;
    end else if (re_i == READ_ENABLE) begin
      rdata_o = word_i;
    end else begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/regfile.sv
// Integer register file x0..x31: one write port from mem_wb, two bypassed
// operand read ports for id, and one raw debug read port.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [ADDR_W-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  localparam int NUM_RD = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  logic [NUM_RD-1:0]             w_re;
  logic [NUM_RD-1:0][ADDR_W-1:0] w_raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] w_word;
  logic [NUM_RD-1:0][DATA_W-1:0] w_rdata;

  // x0 is only ever cleared, so it reads as zero even from raw storage.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i == RST_ENABLE) begin
      r_regs <= '0;
    end else if ((we_i == WRITE_ENABLE) && (waddr_i != '0)) begin
      r_regs[waddr_i] <= wdata_i;
    end
  end

  assign w_re    = {re2_i, re1_i};
  assign w_raddr = {raddr2_i, raddr1_i};

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      assign w_word[g] = r_regs[w_raddr[g]];

      regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_rd_port (
        .rst_i   (rst_i),
        .re_i    (w_re[g]),
        .raddr_i (w_raddr[g]),
        .we_i    (we_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i),
        .word_i  (w_word[g]),
        .rdata_o (w_rdata[g])
      );
    end
  endgenerate

  assign rdata1_o = w_rdata[0];
  assign rdata2_o = w_rdata[1];

  // Debug sees storage only: a write shows up the cycle after its edge.
  always_comb begin
    dbg_rdata_o = '0;
    if ((rst_i != RST_ENABLE) && (dbg_raddr_i != '0)) begin
      dbg_rdata_o = r_regs[dbg_raddr_i];
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed and random checks of regfile read priority, bypass, x0 and reset,
// using a queue of expected outputs and a reference register model.
module tb_regfile;

  logic        clk;
  logic        rst_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic [4:0]  dbg_raddr_i;
  logic [31:0] dbg_rdata_o;

  regfile dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .we_i        (we_i),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .re1_i       (re1_i),
    .raddr1_i    (raddr1_i),
    .rdata1_o    (rdata1_o),
    .re2_i       (re2_i),
    .raddr2_i    (raddr2_i),
    .rdata2_o    (rdata2_o),
    .dbg_raddr_i (dbg_raddr_i),
    .dbg_rdata_o (dbg_rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          checks;
  int          failures;

  task automatic expect_out(input string tag, input int port, input logic [31:0] e);
    exp_t x;
    x.tag  = tag;
    x.port = port;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.port)
        1:       obs = rdata1_o;
        2:       obs = rdata2_o;
        default: obs = dbg_rdata_o;
      endcase
      checks++;
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Advance to the next falling edge, passing one rising edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    cyc();
    if (a != 5'd0) mdl[a] = d;
    we_i = 1'b0;
  endtask

  function automatic logic [31:0] port_model(input logic re, input logic [4:0] a);
    if (rst_i) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (!re) return 32'h0;
    if (we_i && (waddr_i == a)) return wdata_i;
    return mdl[a];
  endfunction

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_i = 1'b1; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    re1_i = 1'b1; raddr1_i = 5'd3; re2_i = 1'b1; raddr2_i = 5'd4; dbg_raddr_i = 5'd5;
    @(negedge clk); @(negedge clk);

    expect_out("rst_rd1", 1, 32'h0);
    expect_out("rst_rd2", 2, 32'h0);
    expect_out("rst_dbg", 3, 32'h0);
    drain();
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 1; i < 32; i++) wr(5'(i), (32'(i) * 32'h01010101) ^ 32'hC0000000);
    for (int i = 1; i < 32; i++) begin
      raddr1_i = 5'(i); raddr2_i = 5'(32 - i); dbg_raddr_i = 5'(i);
      #2;
      expect_out($sformatf("fill_rd1_x%0d", i), 1, mdl[i]);
      expect_out($sformatf("fill_rd2_x%0d", 32 - i), 2, mdl[32 - i]);
      expect_out($sformatf("fill_dbg_x%0d", i), 3, mdl[i]);
      drain();
    end

    // Reset asserted away from any clock edge must clear outputs at once.
    raddr1_i = 5'd10; raddr2_i = 5'd20; dbg_raddr_i = 5'd30;
    #1;
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    #1;
    expect_out("midrst_rd1", 1, 32'h0);
    expect_out("midrst_rd2", 2, 32'h0);
    expect_out("midrst_dbg", 3, 32'h0);
    drain();
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 1; i < 32; i++) begin
      raddr1_i = 5'(i); dbg_raddr_i = 5'(i);
      #1;
      expect_out($sformatf("postrst_rd1_x%0d", i), 1, 32'h0);
      expect_out($sformatf("postrst_dbg_x%0d", i), 3, 32'h0);
      drain();
    end
    @(negedge clk);

    wr(5'd5, 32'hDEADBEEF);
    re1_i = 1'b1; raddr1_i = 5'd5; dbg_raddr_i = 5'd5;
    #2;
    expect_out("x5_rd1", 1, 32'hDEADBEEF);
    expect_out("x5_dbg", 3, 32'hDEADBEEF);
    drain();

    we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'hFFFFFFFF;
    re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd0; raddr2_i = 5'd0; dbg_raddr_i = 5'd0;
    #2;
    expect_out("x0_same_rd1", 1, 32'h0);
    expect_out("x0_same_rd2", 2, 32'h0);
    expect_out("x0_same_dbg", 3, 32'h0);
    drain();
    cyc();
    we_i = 1'b0;
    #2;
    expect_out("x0_next_rd1", 1, 32'h0);
    expect_out("x0_next_rd2", 2, 32'h0);
    expect_out("x0_next_dbg", 3, 32'h0);
    drain();

    wr(5'd7, 32'h1);
    we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h12345678;
    re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd7; raddr2_i = 5'd7; dbg_raddr_i = 5'd7;
    #2;
    expect_out("byp_rd1", 1, 32'h12345678);
    expect_out("byp_rd2", 2, 32'h12345678);
    expect_out("byp_dbg_old", 3, 32'h1);
    drain();
    re2_i = 1'b0;
    #1;
    expect_out("byp_rd2_disabled", 2, 32'h0);
    drain();
    re2_i = 1'b1;
    cyc();
    mdl[7] = 32'h12345678;
    we_i = 1'b0;
    #2;
    expect_out("byp_dbg_new", 3, 32'h12345678);
    drain();

    re1_i = 1'b1; raddr1_i = 5'd7; re2_i = 1'b0; raddr2_i = 5'd7;
    #2;
    expect_out("rdis_rd1", 1, 32'h12345678);
    expect_out("rdis_rd2", 2, 32'h0);
    drain();
    re2_i = 1'b1;

    @(negedge clk);
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hA5A5A5A5;
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    cyc();
    rst_i = 1'b0; we_i = 1'b0;
    raddr1_i = 5'd9; dbg_raddr_i = 5'd9; raddr2_i = 5'd7;
    #2;
    expect_out("coll_rd1_x9", 1, 32'h0);
    expect_out("coll_dbg_x9", 3, 32'h0);
    expect_out("coll_rd2_x7", 2, 32'h0);
    drain();

    @(negedge clk);
    for (int n = 0; n < 200; n++) begin
      we_i = 1'($urandom_range(0, 1));
      waddr_i = 5'($urandom_range(0, 7));
      wdata_i = $urandom();
      re1_i = ($urandom_range(0, 3) != 0);
      re2_i = ($urandom_range(0, 3) != 0);
      raddr1_i = 5'($urandom_range(0, 7));
      raddr2_i = 5'($urandom_range(0, 7));
      dbg_raddr_i = 5'($urandom_range(0, 7));
      #2;
      expect_out($sformatf("rnd%0d_rd1", n), 1, port_model(re1_i, raddr1_i));
      expect_out($sformatf("rnd%0d_rd2", n), 2, port_model(re2_i, raddr2_i));
      expect_out($sformatf("rnd%0d_dbg", n), 3, (dbg_raddr_i == 5'd0) ? 32'h0 : mdl[dbg_raddr_i]);
      drain();
      cyc();
      if (we_i && waddr_i != 5'd0) mdl[waddr_i] = wdata_i;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
